fp_unpack_pipe: RTL and testbench

//  Operand unpacker at the FPU front end; the inverse of the rounder's normalise/pack path. Takes a packed

---
 rtl/fp_unpack_pipe.sv | 91 +++++++++
 tb/tb_fp_unpack_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: two-stage IEEE-754 single/double operand unpacker with class decode and denormal pre-normalisation
module fp_unpack_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] fa,
  input  logic        db,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sa,
  output logic [12:0] ea,
  output logic [52:0] fna,
  output logic [5:0]  lza,
  output logic        dbo,
  output logic        ZERO,
  output logic        INF,
  output logic        NAN,
  output logic        SNAN,
  output logic        DENORM
);
  logic        s1_v, s2_v, s1_load, s2_load;
  logic [10:0] e, emax;
  logic [51:0] f;
  logic [5:0]  clz;
  logic        ez, em, fz;
  logic [4:0]  c;
  logic        s1_s, s1_db;
  logic [10:0] s1_e;
  logic [51:0] s1_f;
  logic [5:0]  s1_lz;
  logic [4:0]  s1_c;
  logic [12:0] bias, ea_n;
  assign s2_load   = !s2_v || out_ready;
  assign s1_load   = !s1_v || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_v;
  assign e    = db ? fa[62:52] : {3'b0, fa[30:23]};
  assign f    = db ? fa[51:0] : {fa[22:0], 29'b0};
  assign emax = db ? 11'h7ff : 11'h0ff;
  assign ez   = e == 11'd0;
  assign em   = e == emax;
  assign fz   = f == 52'd0;
  assign c    = {ez && fz, em && fz, em && !fz, em && !fz && !f[51], ez && !fz};
  always_comb begin
    clz = 6'd0;
    for (int i = 0; i < 52; i++) if (f[i]) clz = 6'(51 - i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_s  <= 1'b0;
      s1_db <= 1'b0;
      s1_e  <= '0;
      s1_f  <= '0;
      s1_lz <= '0;
      s1_c  <= '0;
    end else if (s1_load) begin
      s1_v  <= in_valid;
      s1_s  <= db ? fa[63] : fa[31];
      s1_db <= db;
      s1_e  <= e;
      s1_f  <= f;
      s1_lz <= c[0] ? clz + 6'd1 : 6'd0;
      s1_c  <= c;
    end
  end
  assign bias = s1_db ? 13'd1023 : 13'd127;
  assign ea_n = s1_c[4] ? 13'd0 : s1_c[0] ? 13'd1 - bias - {7'b0, s1_lz} : {2'b0, s1_e} - bias;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v <= 1'b0;
      sa   <= 1'b0;
      ea   <= '0;
      fna  <= '0;
      lza  <= '0;
      dbo  <= 1'b0;
      {ZERO, INF, NAN, SNAN, DENORM} <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        sa   <= s1_s;
        ea   <= ea_n;
        fna  <= {s1_e != 11'd0, s1_f} << s1_lz;
        lza  <= s1_lz;
        dbo  <= s1_db;
        {ZERO, INF, NAN, SNAN, DENORM} <= s1_c;
      end
    end
  end
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb_fp_unpack_pipe: directed self-checking bench for fp_unpack_pipe
module tb_fp_unpack_pipe;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, db = 1'b0, out_ready = 1'b1;
  logic [63:0] fa = '0;
  logic        in_ready, out_valid, sa, dbo, ZERO, INF, NAN, SNAN, DENORM;
  logic [12:0] ea;
  logic [52:0] fna;
  logic [5:0]  lza;
  int checks = 0, errors = 0, rcv = 0;
  fp_unpack_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fa(fa), .db(db),
    .out_valid(out_valid), .out_ready(out_ready), .sa(sa), .ea(ea), .fna(fna), .lza(lza),
    .dbo(dbo), .ZERO(ZERO), .INF(INF), .NAN(NAN), .SNAN(SNAN), .DENORM(DENORM)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [63:0] a, input logic d, input logic s,
                    input logic [12:0] e, input logic [52:0] f, input logic [5:0] l, input logic [4:0] c);
    @(posedge clk);
    #1 in_valid = 1'b1; fa = a; db = d;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, ".lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".sa"}, 64'(sa), 64'(s));
    chk({tag, ".ea"}, 64'(ea), 64'(e));
    chk({tag, ".fna"}, 64'(fna), 64'(f));
    chk({tag, ".lza"}, 64'(lza), 64'(l));
    chk({tag, ".dbo"}, 64'(dbo), 64'(d));
    chk({tag, ".flags"}, 64'({ZERO, INF, NAN, SNAN, DENORM}), 64'(c));
  endtask
  initial begin
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.fna", 64'(fna), 64'd0);
    chk("rst.ea", 64'(ea), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst.in_ready", 64'(in_ready), 64'd1);
    op("d_one",     64'h3FF0000000000000, 1'b1, 1'b0, 13'h0000, 53'h10000000000000, 6'd0,  5'b00000);
    op("d_minden",  64'h0000000000000001, 1'b1, 1'b0, 13'h1BCE, 53'h10000000000000, 6'd52, 5'b00001);
    op("s_minden",  64'hFFFFFFFF00000001, 1'b0, 1'b0, 13'h1F6B, 53'h10000000000000, 6'd23, 5'b00001);
    op("s_1p5",     64'h000000003FC00000, 1'b0, 1'b0, 13'h0000, 53'h18000000000000, 6'd0,  5'b00000);
    op("d_inf",     64'h7FF0000000000000, 1'b1, 1'b0, 13'd1024, 53'h10000000000000, 6'd0,  5'b01000);
    op("d_snan",    64'h7FF4000000000000, 1'b1, 1'b0, 13'd1024, 53'h14000000000000, 6'd0,  5'b00110);
    op("d_negzero", 64'h8000000000000000, 1'b1, 1'b1, 13'h0000, 53'h00000000000000, 6'd0,  5'b10000);
    op("s_neginf",  64'h00000000FF800000, 1'b0, 1'b1, 13'd128,  53'h10000000000000, 6'd0,  5'b01000);
    op("s_qnan",    64'h000000007FC00000, 1'b0, 1'b0, 13'd128,  53'h18000000000000, 6'd0,  5'b00100);
    op("s_zero",    64'h1234567800000000, 1'b0, 1'b0, 13'h0000, 53'h00000000000000, 6'd0,  5'b10000);
    op("d_maxden",  64'h000FFFFFFFFFFFFF, 1'b1, 1'b0, 13'h1C01, 53'h1FFFFFFFFFFFFE, 6'd1,  5'b00001);
    op("d_minnorm", 64'h0010000000000000, 1'b1, 1'b0, 13'h1C02, 53'h10000000000000, 6'd0,  5'b00000);
    op("s_maxnorm", 64'h000000007F7FFFFF, 1'b0, 1'b0, 13'd127,  53'h1FFFFFE0000000, 6'd0,  5'b00000);
    op("d_neg2",    64'hC000000000000000, 1'b1, 1'b1, 13'd1,    53'h10000000000000, 6'd0,  5'b00000);
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic acc;
          int g = 0;
          in_valid = 1'b1; db = 1'b1; fa = 64'h3FF0000000000000 | 64'(i);
          do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1 g++;
          end while (!acc && g < 100);
          if (!acc) chk("stream.accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin
        int g = 0;
        while (rcv < 8 && g < 200) begin
          @(negedge clk);
          g++;
          if (out_valid && out_ready) begin
            chk("stream.fna", 64'(fna), 64'(53'h10000000000000 | 53'(rcv)));
            chk("stream.ea", 64'(ea), 64'd0);
            rcv++;
          end
        end
        chk("stream.count", 64'(rcv), 64'd8);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall.valid", 64'(out_valid), 64'd1);
          chk("stall.fna", 64'(fna), 64'(53'h10000000000000 | 53'(rcv)));
          chk("stall.in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) begin
      @(negedge clk);
      chk("stream.nodup", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1; db = 1'b1; fa = 64'hC000000000000000;
    @(posedge clk);
    #1 fa = 64'h3FF0000000000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("full.out_valid", 64'(out_valid), 64'd1);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.sa", 64'(sa), 64'd0);
    chk("arst.ea", 64'(ea), 64'd0);
    chk("arst.fna", 64'(fna), 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    op("post_rst",  64'h000000003F800000, 1'b0, 1'b0, 13'h0000, 53'h10000000000000, 6'd0,  5'b00000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
